// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer.
// Provides the Q2.14 data type, the FSM state encoding, the rotation
// constants and the arctangent table used by the micro-rotation step.
package cordic_pkg;

   localparam int unsigned WIDTH    = 16;   // Q2.14, 1.0 = 16384
   localparam int unsigned ATAN_LEN = 16;   // entries in the atan table
   localparam int unsigned IDX_W    = 4;    // bits to index the atan table

   typedef logic signed [WIDTH-1:0] data_t;
   typedef logic [IDX_W-1:0]        idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Initial x pre-scaled by the inverse CORDIC gain so the result is unit-length.
   localparam data_t K_INIT      = data_t'(9949);
   localparam data_t HALF_PI     = data_t'(25736);
   localparam data_t NEG_HALF_PI = data_t'(-25736);

   // atan(2^-i) in Q2.14.
   function automatic data_t atan_lut(input idx_t i);
      data_t v;
      unique case (i)
         4'd0:    v = data_t'(12868);
         4'd1:    v = data_t'(7596);
         4'd2:    v = data_t'(4014);
         4'd3:    v = data_t'(2037);
         4'd4:    v = data_t'(1023);
         4'd5:    v = data_t'(512);
         4'd6:    v = data_t'(256);
         4'd7:    v = data_t'(128);
         4'd8:    v = data_t'(64);
         4'd9:    v = data_t'(32);
         4'd10:   v = data_t'(16);
         4'd11:   v = data_t'(8);
         4'd12:   v = data_t'(4);
         4'd13:   v = data_t'(2);
         4'd14:   v = data_t'(1);
         default: v = data_t'(0);
      endcase
      return v;
   endfunction

   // True when the angle lies outside [-pi/2, +pi/2].
   function automatic logic angle_out_of_range(input data_t a);
      return (a > HALF_PI) || (a < NEG_HALF_PI);
   endfunction

   // Saturate the angle into the convergence domain of rotation-mode CORDIC.
   function automatic data_t clamp_angle(input data_t a);
      data_t r;
      if (a > HALF_PI) begin
         r = HALF_PI;
      end else if (a < NEG_HALF_PI) begin
         r = NEG_HALF_PI;
      end else begin
         r = a;
      end
      return r;
   endfunction

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Handshake bundle for the iterative CORDIC sequencer.
//   in_valid/in_ready/in_angle     : angle request channel (producer -> block)
//   out_valid/out_ready/out_cos/out_sin/out_sat : result channel (block -> consumer)
//   busy                           : operation in flight
// master = the environment (phase accumulator / mixer side), slave = the block.
interface cordic_iter_ctrl_if;
   import cordic_pkg::*;

   logic  in_valid;
   logic  in_ready;
   data_t in_angle;
   logic  out_valid;
   logic  out_ready;
   data_t out_cos;
   data_t out_sin;
   logic  out_sat;
   logic  busy;

   modport master (
      output in_valid, in_angle, out_ready,
      input  in_ready, out_valid, out_cos, out_sin, out_sat, busy
   );

   modport slave (
      input  in_valid, in_angle, out_ready,
      output in_ready, out_valid, out_cos, out_sin, out_sat, busy
   );

endinterface

// File: rtl/cordic_iter_step.sv
// One combinational CORDIC micro-rotation in rotation mode.
//   x_i, y_i, z_i : current vector and residual angle (Q2.14)
//   shift_i       : iteration index i, used as the arithmetic shift amount
//   c_i           : atan(2^-i) for this iteration
//   x_c, y_c, z_c : rotated vector and updated residual angle
// Direction follows the sign of z: rotate toward driving the residual to zero.
module cordic_iter_step
   import cordic_pkg::*;
(
   input  data_t x_i,
   input  data_t y_i,
   input  data_t z_i,
   input  idx_t  shift_i,
   input  data_t c_i,
   output data_t x_c,
   output data_t y_c,
   output data_t z_c
);

   logic  neg_c;
   data_t x_sh_c;
   data_t y_sh_c;

   assign neg_c  = z_i[WIDTH-1];
   assign x_sh_c = x_i >>> shift_i;
   assign y_sh_c = y_i >>> shift_i;

   // d = +1 when z >= 0, -1 otherwise; sums wrap at WIDTH bits.
   assign x_c = neg_c ? data_t'(x_i + y_sh_c) : data_t'(x_i - y_sh_c);
   assign y_c = neg_c ? data_t'(y_i - x_sh_c) : data_t'(y_i + x_sh_c);
   assign z_c = neg_c ? data_t'(z_i + c_i)    : data_t'(z_i - c_i);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: computes cos/sin of one angle by reusing a
// single micro-rotation for ITER cycles, one operation in flight.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : slave side of the request/result handshake (see cordic_iter_ctrl_if)
// Flow: IDLE accepts and clamps an angle, RUN performs ITER rotations,
// DONE presents the result until the consumer takes it.
module cordic_iter_ctrl
   import cordic_pkg::*;
#(
   parameter int unsigned ITER = 16
)
(
   input  logic               clock,
   input  logic               reset,
   cordic_iter_ctrl_if.slave  bus
);

   // The iteration count is bounded by the atan table length.
   if (ITER < 1 || ITER > ATAN_LEN) begin : g_bad_iter
      $error("cordic_iter_ctrl: ITER must be in 1..%0d", ATAN_LEN);
   end

   localparam idx_t LAST_IDX = idx_t'(ITER - 1);

   state_t state_q,     state_d;
   idx_t   iter_q,      iter_d;
   data_t  x_q,         x_d;
   data_t  y_q,         y_d;
   data_t  z_q,         z_d;
   data_t  cos_q,       cos_d;
   data_t  sin_q,       sin_d;
   logic   sat_q,       sat_d;
   logic   out_valid_q, out_valid_d;
   logic   in_ready_q,  in_ready_d;
   logic   busy_q,      busy_d;

   data_t  x_step_c;
   data_t  y_step_c;
   data_t  z_step_c;

   // Shared micro-rotation datapath.
   cordic_iter_step u_step (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .shift_i (iter_q),
      .c_i     (atan_lut(iter_q)),
      .x_c     (x_step_c),
      .y_c     (y_step_c),
      .z_c     (z_step_c)
   );

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      cos_d       = cos_q;
      sin_d       = sin_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d        = K_INIT;
               y_d        = '0;
               z_d        = clamp_angle(bus.in_angle);
               sat_d      = angle_out_of_range(bus.in_angle);
               iter_d     = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end

         RUN: begin
            x_d    = x_step_c;
            y_d    = y_step_c;
            z_d    = z_step_c;
            iter_d = idx_t'(iter_q + idx_t'(1));
            // Capture the final rotation straight into the result registers.
            if (iter_q == LAST_IDX) begin
               state_d     = DONE;
               cos_d       = x_step_c;
               sin_d       = y_step_c;
               out_valid_d = 1'b1;
            end
         end

         DONE: begin
            // in_ready stays low here, forcing one IDLE cycle between operations.
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         iter_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         cos_q       <= '0;
         sin_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         cos_q       <= cos_d;
         sin_q       <= sin_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_cos   = cos_q;
   assign bus.out_sin   = sin_q;
   assign bus.out_sat   = sat_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: a per-cycle monitor compares the
// DUT against a transaction-level model (queue of accepted angles, real-valued
// cos/sin), while the driver runs directed and randomized scenarios.
module tb_cordic_iter_ctrl;
   import cordic_pkg::*;

   localparam int ITER = 16;
   localparam int HP   = 25736;
   localparam int TOL  = 8;

   logic clk;
   logic reset;

   cordic_iter_ctrl_if bus ();

   cordic_iter_ctrl #(.ITER(ITER)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int clampa(input int a);
      return (a > HP) ? HP : ((a < -HP) ? -HP : a);
   endfunction

   function automatic int model_cos(input int a);
      return int'($cos(real'(clampa(a)) / 16384.0) * 16384.0);
   endfunction

   function automatic int model_sin(input int a);
      return int'($sin(real'(clampa(a)) / 16384.0) * 16384.0);
   endfunction

   function automatic bit near(input int a, input int e);
      return (a - e <= TOL) && (e - a <= TOL);
   endfunction

   // ---------------- transaction-level model + per-cycle compare ----------------
   int q[$];
   int acc_hist[$];
   int cyc      = 0;
   int acc_cyc  = 0;
   int pop_cyc  = 0;
   int rise_cyc = 0;
   int acc_cnt  = 0;
   int pop_cnt  = 0;
   int rise_cnt = 0;
   int last_cos, last_sin, last_sat;
   int prev_cos, prev_sin, prev_sat;
   bit armed    = 0;
   bit hold_prev = 0;
   bit m_valid;
   bit m_idle;

   always @(negedge clk) begin
      cyc++;
      if (armed) begin
         m_idle  = (q.size() == 0);
         m_valid = !m_idle && (cyc >= acc_cyc + ITER + 1);
         chk("in_ready",  bus.in_ready  === m_idle,   int'(bus.in_ready),  int'(m_idle));
         chk("busy",      bus.busy      === !m_idle,  int'(bus.busy),      int'(!m_idle));
         chk("out_valid", bus.out_valid === m_valid,  int'(bus.out_valid), int'(m_valid));
         if (m_valid) begin
            if (!hold_prev) begin
               chk("cos", near(int'(bus.out_cos), model_cos(q[0])), int'(bus.out_cos), model_cos(q[0]));
               chk("sin", near(int'(bus.out_sin), model_sin(q[0])), int'(bus.out_sin), model_sin(q[0]));
               chk("sat", bus.out_sat === (q[0] != clampa(q[0])), int'(bus.out_sat), int'(q[0] != clampa(q[0])));
               last_cos = int'(bus.out_cos);
               last_sin = int'(bus.out_sin);
               last_sat = int'(bus.out_sat);
               rise_cyc = cyc;
               rise_cnt++;
            end else begin
               chk("hold_cos", int'(bus.out_cos) == prev_cos, int'(bus.out_cos), prev_cos);
               chk("hold_sin", int'(bus.out_sin) == prev_sin, int'(bus.out_sin), prev_sin);
               chk("hold_sat", int'(bus.out_sat) == prev_sat, int'(bus.out_sat), prev_sat);
            end
            prev_cos = int'(bus.out_cos);
            prev_sin = int'(bus.out_sin);
            prev_sat = int'(bus.out_sat);
         end
         hold_prev = m_valid && !bus.out_ready;
         if (!reset) begin
            if (m_valid && bus.out_ready) begin
               void'(q.pop_front());
               pop_cyc = cyc;
               pop_cnt++;
            end else if (m_idle && bus.in_valid) begin
               q.push_back(int'(bus.in_angle));
               acc_cyc = cyc;
               acc_hist.push_back(cyc);
               acc_cnt++;
            end
         end
      end
      if (reset) begin
         armed     = 1;
         hold_prev = 0;
         q.delete();
      end
   end

   // ---------------- driver helpers ----------------
   task automatic send(input int a);
      int start;
      start = acc_cnt;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_angle = data_t'(a);
      for (int k = 0; k < 200 && acc_cnt == start; k++) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_angle = data_t'($urandom);
      if (acc_cnt == start) chk("accept_timeout", 1'b0, 0, 1);
   endtask

   task automatic wait_pop(input int target);
      for (int k = 0; k < 400 && pop_cnt < target; k++) begin
         @(posedge clk); #1;
      end
      if (pop_cnt < target) chk("result_timeout", 1'b0, pop_cnt, target);
   endtask

   task automatic wait_rise(input int target);
      for (int k = 0; k < 100 && rise_cnt < target; k++) begin
         @(posedge clk); #1;
      end
      if (rise_cnt < target) chk("valid_timeout", 1'b0, rise_cnt, target);
   endtask

   task automatic directed(input int a, input int ec, input int es, input int esat);
      send(a);
      wait_pop(pop_cnt + 1);
      chk("lit_cos", near(last_cos, ec), last_cos, ec);
      chk("lit_sin", near(last_sin, es), last_sin, es);
      chk("lit_sat", last_sat == esat,   last_sat, esat);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int ang [5];
      int n0, a0;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_angle  = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid === 1'b0, int'(bus.out_valid), 0);
      chk("rst_in_ready",  bus.in_ready  === 1'b1, int'(bus.in_ready),  1);
      chk("rst_busy",      bus.busy      === 1'b0, int'(bus.busy),      0);
      chk("rst_cos",       bus.out_cos   === '0,   int'(bus.out_cos),   0);
      chk("rst_sin",       bus.out_sin   === '0,   int'(bus.out_sin),   0);
      chk("rst_sat",       bus.out_sat   === 1'b0, int'(bus.out_sat),   0);
      reset = 1'b0;

      // Angle 0, consumer always ready: latency and basic result.
      bus.out_ready = 1'b1;
      send(0);
      chk("in_ready_after_accept", bus.in_ready === 1'b0, int'(bus.in_ready), 0);
      wait_pop(1);
      chk("latency", rise_cyc - acc_cyc == ITER + 1, rise_cyc - acc_cyc, ITER + 1);
      chk("lit_cos0", near(last_cos, 16384), last_cos, 16384);
      chk("lit_sin0", near(last_sin, 0),     last_sin, 0);
      chk("lit_sat0", last_sat == 0,         last_sat, 0);

      directed(25736,   0,     16384,  0);
      directed(-12868,  11585, -11585, 0);
      directed(30000,   0,     16384,  1);
      directed(-32768,  0,     -16384, 1);

      // Backpressure: result held, stray request ignored, then release.
      bus.out_ready = 1'b0;
      send(5000);
      wait_rise(rise_cnt + 1);
      n0 = acc_cnt;
      repeat (10) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_angle = data_t'(7000);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("no_accept_while_done", acc_cnt == n0, acc_cnt, n0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_angle  = data_t'(-7000);
      for (int k = 0; k < 10 && acc_cnt == n0; k++) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("accept_after_release", acc_cyc - pop_cyc == 1, acc_cyc - pop_cyc, 1);
      wait_pop(pop_cnt + 1);

      // Reset at iteration 7 aborts the operation.
      n0 = pop_cnt;
      send(8000);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_out_valid", bus.out_valid === 1'b0, int'(bus.out_valid), 0);
      chk("abort_in_ready",  bus.in_ready  === 1'b1, int'(bus.in_ready),  1);
      chk("abort_no_result", pop_cnt == n0, pop_cnt, n0);
      directed(-20000, model_cos(-20000), model_sin(-20000), 0);

      // Back-to-back with both handshakes held high.
      for (int k = 0; k < 5; k++) ang[k] = int'($urandom_range(2 * HP)) - HP;
      n0 = pop_cnt;
      a0 = acc_hist.size();
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int start;
         start = acc_cnt;
         bus.in_angle = data_t'(ang[k]);
         for (int t = 0; t < 100 && acc_cnt == start; t++) begin
            @(posedge clk); #1;
         end
         if (acc_cnt == start) chk("b2b_timeout", 1'b0, k, 5);
      end
      bus.in_valid = 1'b0;
      wait_pop(n0 + 5);
      for (int k = a0 + 1; k < a0 + 5 && k < acc_hist.size(); k++)
         chk("b2b_spacing", acc_hist[k] - acc_hist[k-1] == ITER + 2,
             acc_hist[k] - acc_hist[k-1], ITER + 2);

      // Randomized angles (including out-of-range) with random backpressure.
      for (int k = 0; k < 10; k++) begin
         int target;
         target = pop_cnt + 1;
         send(int'($urandom_range(65535)) - 32768);
         for (int t = 0; t < 300 && pop_cnt < target; t++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(3) != 0);
         end
         if (pop_cnt < target) chk("rand_timeout", 1'b0, pop_cnt, target);
      end
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
